// File: rtl/dl_monitor_pkg.sv
// Shared types and width helpers for the dataflow deadlock monitor.
// Optional member tracking is enabled with DL_MONITOR_MEMBERS_EN.
package dl_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WALK,
    S_FOUND
  } dl_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/dl_stable_tracker.sv
// Input snapshot, change detect, stability and stall counters
// for the dataflow deadlock monitor.
module dl_stable_tracker
  import dl_monitor_pkg::*;
#(
  parameter int N_PROC        = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_W     = 16,
  parameter int IDX_W         = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [N_PROC-1:0]       i_proc_blk,
  input  logic [N_PROC*IDX_W-1:0] i_proc_wait_idx,
  output logic [N_PROC-1:0]       o_blk_q,
  output logic [N_PROC*IDX_W-1:0] o_wait_q,
  output logic                    o_chg,
  output logic                    o_stable,
  output logic [TIMEOUT_W-1:0]    o_stall_cnt
);

  localparam int SC_W = idx_w(STABLE_CYCLES);
  localparam logic [SC_W-1:0] SC_MAX =
    SC_W'(STABLE_CYCLES - 1);

  logic [N_PROC-1:0]       r_blk_q;
  logic [N_PROC*IDX_W-1:0] r_wait_q;
  logic [SC_W-1:0]         r_stable_cnt;
  logic [TIMEOUT_W-1:0]    r_stall_cnt;
  logic                    w_chg;

  assign w_chg = (i_proc_blk != r_blk_q) ||
                 (i_proc_wait_idx != r_wait_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blk_q      <= '0;
      r_wait_q     <= '0;
      r_stable_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_blk_q  <= i_proc_blk;
      r_wait_q <= i_proc_wait_idx;
      if (w_chg)
        r_stable_cnt <= '0;
      else if (r_stable_cnt != SC_MAX)
        r_stable_cnt <= r_stable_cnt + 1'b1;
      // stall time only accrues while monitoring
      if (i_en) begin
        if (w_chg || (i_proc_blk == '0))
          r_stall_cnt <= '0;
        else if (r_stall_cnt != '1)
          r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign o_blk_q     = r_blk_q;
  assign o_wait_q    = r_wait_q;
  assign o_chg       = w_chg;
  assign o_stable    = (r_stable_cnt == SC_MAX);
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/hls_dataflow_deadlock_monitor.sv
// N-process wait-for cycle detector for an HLS dataflow region.
// Define DL_MONITOR_MEMBERS_EN to add the o_dl_members port.
module hls_dataflow_deadlock_monitor
  import dl_monitor_pkg::*;
#(
  parameter int N_PROC        = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_W     = 16,
  localparam int IDX_W        = idx_w(N_PROC)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [N_PROC-1:0]       i_proc_blk,
  input  logic [N_PROC*IDX_W-1:0] i_proc_wait_idx,
  input  logic                    i_clear,
  output logic                    o_dl_detect,
  output logic [IDX_W-1:0]        o_dl_origin,
  output logic [IDX_W:0]          o_dl_len,
  output logic [TIMEOUT_W-1:0]    o_stall_cnt,
  output logic                    o_busy
`ifdef DL_MONITOR_MEMBERS_EN
  ,output logic [N_PROC-1:0]      o_dl_members
`endif
);

  localparam int NP2 = 1 << IDX_W;
  localparam logic [IDX_W:0] NP_L = (IDX_W+1)'(N_PROC);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PROC - 1);

  logic [N_PROC-1:0]       w_blk_q;
  logic [N_PROC*IDX_W-1:0] w_wait_q;
  logic                    w_chg;
  logic                    w_stable;
  logic [IDX_W-1:0]        w_wait [NP2];
  logic [NP2-1:0]          w_blk_pad;

  dl_stable_tracker #(
    .N_PROC       (N_PROC),
    .STABLE_CYCLES(STABLE_CYCLES),
    .TIMEOUT_W    (TIMEOUT_W),
    .IDX_W        (IDX_W)
  ) u_trk (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_en           (i_en),
    .i_proc_blk     (i_proc_blk),
    .i_proc_wait_idx(i_proc_wait_idx),
    .o_blk_q        (w_blk_q),
    .o_wait_q       (w_wait_q),
    .o_chg          (w_chg),
    .o_stable       (w_stable),
    .o_stall_cnt    (o_stall_cnt)
  );

  // padded to a power of two so any index is safe; an invalid target blocks nothing
  for (genvar g = 0; g < NP2; g++) begin : g_wait
    if (g < N_PROC) begin : g_v
      assign w_wait[g] = w_wait_q[g*IDX_W +: IDX_W];
      assign w_blk_pad[g] = w_blk_q[g] &
        ({1'b0, w_wait[g]} < NP_L);
    end else begin : g_z
      assign w_wait[g]    = '0;
      assign w_blk_pad[g] = 1'b0;
    end
  end

  dl_state_e        r_state;
  logic [IDX_W-1:0] r_origin;
  logic [IDX_W-1:0] r_cur;
  logic [IDX_W:0]   r_hop;
  logic             r_detect;
  logic [IDX_W-1:0] r_dl_origin;
  logic [IDX_W:0]   r_dl_len;

  logic             w_go;
  logic [IDX_W-1:0] w_next;
  logic [IDX_W:0]   w_hop1;
  logic [IDX_W-1:0] w_org_nxt;
  logic             w_walk;
  logic             w_start;
  logic             w_abort;
  logic             w_found;
  logic             w_fail;
  logic             w_step;
  logic             w_rot;

  assign w_go      = i_en & ~w_chg & w_stable;
  assign w_next    = w_wait[r_cur];
  assign w_hop1    = r_hop + 1'b1;
  assign w_org_nxt = (r_origin == LAST) ? '0 : r_origin + 1'b1;
  assign w_walk    = (r_state == S_WALK);
  assign w_start   = (r_state == S_IDLE) & w_go & w_blk_pad[r_origin];
  assign w_abort   = w_walk & (~i_en | w_chg);
  assign w_found   = w_walk & ~w_abort & (w_next == r_origin);
  assign w_fail    = w_walk & ~w_abort & ~w_found &
                     (~w_blk_pad[w_next] | (w_hop1 == NP_L));
  assign w_step    = w_walk & ~w_abort & ~w_found & ~w_fail;
  assign w_rot     = ((r_state == S_IDLE) & w_go &
                      ~w_blk_pad[r_origin]) | w_fail;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_origin    <= '0;
      r_cur       <= '0;
      r_hop       <= '0;
      r_detect    <= 1'b0;
      r_dl_origin <= '0;
      r_dl_len    <= '0;
    end else if (i_clear) begin
      r_state     <= S_IDLE;
      r_detect    <= 1'b0;
      r_dl_origin <= '0;
      r_dl_len    <= '0;
    end else begin
      if (w_rot) r_origin <= w_org_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_WALK;
            r_cur   <= r_origin;
            r_hop   <= '0;
          end
        end
        S_WALK: begin
          if (w_abort || w_fail) begin
            r_state <= S_IDLE;
          end else if (w_found) begin
            r_state     <= S_FOUND;
            r_detect    <= 1'b1;
            r_dl_origin <= r_origin;
            r_dl_len    <= w_hop1;
          end else begin
            r_cur <= w_next;
            r_hop <= w_hop1;
          end
        end
        S_FOUND: r_state <= S_FOUND;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_dl_detect = r_detect;
  assign o_dl_origin = r_dl_origin;
  assign o_dl_len    = r_dl_len;
  assign o_busy      = (r_state != S_IDLE);

`ifdef DL_MONITOR_MEMBERS_EN
  logic [N_PROC-1:0] r_members;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_members <= '0;
    else if (i_clear || w_abort || w_fail)
      r_members <= '0;
    else if (w_start)
      r_members <= N_PROC'(1) << r_origin;
    else if (w_step)
      r_members <= r_members | (N_PROC'(1) << w_next);
  end

  assign o_dl_members = r_members;
`endif

endmodule

// File: tb/tb_hls_dataflow_deadlock_monitor.sv
// Directed bench for the deadlock monitor: a 2-process and a
// 4-process instance with hand-derived edge-by-edge expectations.
module tb_hls_dataflow_deadlock_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en;
  logic       clr;
  logic [1:0] b2;
  logic [1:0] w2;
  logic [3:0] b4;
  logic [7:0] w4;

  logic        d2, o2, y2;
  logic [1:0]  l2;
  logic [15:0] s2;
  logic        d4, y4;
  logic [1:0]  o4;
  logic [2:0]  l4;
  logic [3:0]  s4;
`ifdef DL_MONITOR_MEMBERS_EN
  logic [1:0]  m2;
  logic [3:0]  m4;
`endif

  int vec = 0;
  int bad = 0;

  hls_dataflow_deadlock_monitor #(
    .N_PROC(2), .STABLE_CYCLES(4), .TIMEOUT_W(16)
  ) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_proc_blk(b2), .i_proc_wait_idx(w2), .i_clear(clr),
    .o_dl_detect(d2), .o_dl_origin(o2), .o_dl_len(l2),
    .o_stall_cnt(s2), .o_busy(y2)
`ifdef DL_MONITOR_MEMBERS_EN
    , .o_dl_members(m2)
`endif
  );

  hls_dataflow_deadlock_monitor #(
    .N_PROC(4), .STABLE_CYCLES(4), .TIMEOUT_W(4)
  ) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_proc_blk(b4), .i_proc_wait_idx(w4), .i_clear(clr),
    .o_dl_detect(d4), .o_dl_origin(o4), .o_dl_len(l4),
    .o_stall_cnt(s4), .o_busy(y4)
`ifdef DL_MONITOR_MEMBERS_EN
    , .o_dl_members(m4)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // next posedge after this returns is "edge 0"
  task automatic do_reset;
    rst_n = 1'b0;
    clr   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    en = 1'b1; clr = 1'b0;
    b2 = 2'b11; w2 = 2'b01; b4 = 4'b1111; w4 = 8'hE4;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({d2, o2, l2, s2, y2} !== 21'd0) begin
      bad++;
      $display("FAIL reset_n2: got %0h want 0", {d2, o2, l2, s2, y2});
    end
    vec++;
    if ({d4, o4, l4, s4, y4} !== 11'd0) begin
      bad++;
      $display("FAIL reset_n4: got %0h want 0", {d4, o4, l4, s4, y4});
    end
  endtask

  task automatic test_n2_basic;
    en = 1'b1; b2 = 2'b11; w2 = 2'b01; b4 = '0; w4 = '0;
    do_reset;
    tick;
    repeat (4) tick;
    vec++;
    if ({d2, y2} !== 2'b01) begin
      bad++;
      $display("FAIL n2_walk_entry: got %b want 01", {d2, y2});
    end
    tick;
    vec++;
    if (d2 !== 1'b0) begin
      bad++;
      $display("FAIL n2_early: got %b want 0", d2);
    end
    tick;
    vec++;
    if ({d2, o2, l2} !== 4'b1010) begin
      bad++;
      $display("FAIL n2_detect: got %b want 1010", {d2, o2, l2});
    end
    vec++;
    if (s2 !== 16'd6) begin
      bad++;
      $display("FAIL n2_stall: got %0d want 6", s2);
    end
`ifdef DL_MONITOR_MEMBERS_EN
    vec++;
    if (m2 !== 2'b11) begin
      bad++;
      $display("FAIL n2_members: got %b want 11", m2);
    end
`endif
  endtask

  task automatic test_clear;
    clr = 1'b1; tick; clr = 1'b0;
    vec++;
    if ({d2, o2, l2, y2} !== 5'd0) begin
      bad++;
      $display("FAIL clear_result: got %b want 00000", {d2, o2, l2, y2});
    end
    tick;
    vec++;
    if (y2 !== 1'b1) begin
      bad++;
      $display("FAIL clear_rewalk: got %b want 1", y2);
    end
    tick; tick;
    vec++;
    if ({d2, l2} !== 3'b110) begin
      bad++;
      $display("FAIL clear_redetect: got %b want 110", {d2, l2});
    end
    clr = 1'b1; tick; clr = 1'b0;
    tick; tick;
    clr = 1'b1; tick; clr = 1'b0;
    vec++;
    if ({d2, y2} !== 2'b00) begin
      bad++;
      $display("FAIL clear_wins: got %b want 00", {d2, y2});
    end
  endtask

  task automatic test_enable;
    en = 1'b0; b2 = 2'b11; w2 = 2'b01;
    do_reset;
    repeat (12) tick;
    vec++;
    if ({d2, y2, s2} !== 18'd0) begin
      bad++;
      $display("FAIL en_off: got %0h want 0", {d2, y2, s2});
    end
    en = 1'b1;
    repeat (3) tick;
    vec++;
    if ({d2, s2} !== {1'b1, 16'd3}) begin
      bad++;
      $display("FAIL en_on: got %0h want 10003", {d2, s2});
    end
  endtask

  task automatic test_tail;
    en = 1'b1; b2 = '0; w2 = '0;
    b4 = 4'b0111; w4 = 8'b00_01_10_01;
    do_reset;
    tick;
    repeat (8) tick;
    vec++;
    if ({d4, y4} !== 2'b00) begin
      bad++;
      $display("FAIL tail_abort: got %b want 00", {d4, y4});
    end
    repeat (2) tick;
    vec++;
    if ({d4, y4} !== 2'b01) begin
      bad++;
      $display("FAIL tail_rewalk: got %b want 01", {d4, y4});
    end
    tick;
    vec++;
    if ({d4, o4, l4} !== 6'b1_01_010) begin
      bad++;
      $display("FAIL tail_detect: got %b want 101010", {d4, o4, l4});
    end
`ifdef DL_MONITOR_MEMBERS_EN
    vec++;
    if (m4 !== 4'b0110) begin
      bad++;
      $display("FAIL tail_members: got %b want 0110", m4);
    end
`endif
  endtask

  task automatic test_rotate;
    b4 = 4'b0110; w4 = 8'b00_11_10_00;
    do_reset;
    tick;
    repeat (3) tick;
    vec++;
    if (s4 !== 4'd3) begin
      bad++;
      $display("FAIL rot_stall3: got %0d want 3", s4);
    end
    repeat (2) tick;
    vec++;
    if (y4 !== 1'b1) begin
      bad++;
      $display("FAIL rot_walk1: got %b want 1", y4);
    end
    repeat (2) tick;
    vec++;
    if (y4 !== 1'b0) begin
      bad++;
      $display("FAIL rot_fail: got %b want 0", y4);
    end
    repeat (33) tick;
    vec++;
    if ({d4, l4, s4} !== {1'b0, 3'd0, 4'd15}) begin
      bad++;
      $display("FAIL rot_sat: got %0h want f", {d4, l4, s4});
    end
  endtask

  task automatic test_abort;
    b4 = 4'b0011; w4 = 8'b00_00_00_01;
    do_reset;
    tick;
    repeat (4) tick;
    vec++;
    if (y4 !== 1'b1) begin
      bad++;
      $display("FAIL abort_walk: got %b want 1", y4);
    end
    w4 = 8'b00_00_11_01;
    tick;
    vec++;
    if ({d4, y4} !== 2'b00) begin
      bad++;
      $display("FAIL abort_idle: got %b want 00", {d4, y4});
    end
    w4 = 8'b00_00_00_01;
    tick;
    repeat (5) tick;
    vec++;
    if (d4 !== 1'b0) begin
      bad++;
      $display("FAIL abort_early: got %b want 0", d4);
    end
    tick;
    vec++;
    if ({d4, o4, l4} !== 6'b1_00_010) begin
      bad++;
      $display("FAIL abort_detect: got %b want 100010", {d4, o4, l4});
    end
  endtask

  task automatic test_selfloop;
    b4 = 4'b0100; w4 = 8'b00_10_00_00;
    do_reset;
    tick;
    repeat (6) tick;
    vec++;
    if ({d4, y4} !== 2'b01) begin
      bad++;
      $display("FAIL self_walk: got %b want 01", {d4, y4});
    end
    tick;
    vec++;
    if ({d4, o4, l4} !== 6'b1_10_001) begin
      bad++;
      $display("FAIL self_detect: got %b want 110001", {d4, o4, l4});
    end
`ifdef DL_MONITOR_MEMBERS_EN
    vec++;
    if (m4 !== 4'b0100) begin
      bad++;
      $display("FAIL self_members: got %b want 0100", m4);
    end
`endif
    repeat (5) tick;
    vec++;
    if ({d4, o4, l4} !== 6'b1_10_001) begin
      bad++;
      $display("FAIL self_sticky: got %b want 110001", {d4, o4, l4});
    end
  endtask

  initial begin
    test_reset;
    test_n2_basic;
    test_clear;
    test_enable;
    test_tail;
    test_rotate;
    test_abort;
    test_selfloop;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
